// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges ID/EX stall requests with the MEM-stage
// bus handshake FSM. Optional STALL_PERF_EN adds stall-cycle counters.
module pipe_stall_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id_i,
   input  logic        stallreq_ex_i,
   input  logic        mem_req_i,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        bus_req_o,
   output logic [31:0] mem_rdata_o,
   output logic        mem_done_o,
   output logic        bus_err_o,
   output logic [5:0]  stall_o
`ifdef STALL_PERF_EN
   ,
   output logic [31:0] stall_cycles_o,
   output logic [31:0] mem_stall_cycles_o
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             timeout_hit;
   logic             stallreq_mem;

   assign timeout_hit  = (cnt == CNT_W'(TIMEOUT - 1));
   assign stallreq_mem = mem_req_i & (state != DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (mem_req_i) state_nxt = WAIT;
         WAIT: if (bus_ack_i || timeout_hit) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Ack is tested first so a same-cycle ack beats the timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         bus_req_o   <= 1'b0;
         mem_rdata_o <= 32'h0;
         bus_err_o   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (mem_req_i) begin
                  cnt       <= '0;
                  bus_req_o <= 1'b1;
               end
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (bus_ack_i) begin
                  mem_rdata_o <= bus_rdata_i;
                  bus_req_o   <= 1'b0;
               end else if (timeout_hit) begin
                  mem_rdata_o <= 32'h0;
                  bus_err_o   <= 1'b1;
                  bus_req_o   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_done_o = (state == DONE);
      if (stallreq_mem) begin
         stall_o = 6'b011111;
      end else if (stallreq_ex_i) begin
         stall_o = 6'b001111;
      end else if (stallreq_id_i) begin
         stall_o = 6'b000111;
      end else begin
         stall_o = 6'b000000;
      end
   end

`ifdef STALL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_o     <= 32'h0;
         mem_stall_cycles_o <= 32'h0;
      end else begin
         if (stall_o != 6'b000000) begin
            stall_cycles_o <= stall_cycles_o + 32'd1;
         end
         if (stallreq_mem) begin
            mem_stall_cycles_o <= mem_stall_cycles_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table, hand sequences
// and randomized traffic against a transaction-level reference model.
module tb_pipe_stall_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id_i;
   logic        stallreq_ex_i;
   logic        mem_req_i;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;
   logic        bus_req_o;
   logic [31:0] mem_rdata_o;
   logic        mem_done_o;
   logic        bus_err_o;
   logic [5:0]  stall_o;
`ifdef STALL_PERF_EN
   logic [31:0] stall_cycles_o;
   logic [31:0] mem_stall_cycles_o;
`endif

   pipe_stall_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .stallreq_id_i (stallreq_id_i),
      .stallreq_ex_i (stallreq_ex_i),
      .mem_req_i     (mem_req_i),
      .bus_ack_i     (bus_ack_i),
      .bus_rdata_i   (bus_rdata_i),
      .bus_req_o     (bus_req_o),
      .mem_rdata_o   (mem_rdata_o),
      .mem_done_o    (mem_done_o),
      .bus_err_o     (bus_err_o),
      .stall_o       (stall_o)
`ifdef STALL_PERF_EN
      ,
      .stall_cycles_o     (stall_cycles_o),
      .mem_stall_cycles_o (mem_stall_cycles_o)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: one bus transaction at a time, tracked by wait count.
   bit          m_busy;
   int          m_waits;
   bit          m_done;
   bit          m_req;
   bit          m_err;
   logic [31:0] m_rdata;
   int unsigned m_stall_cnt;
   int unsigned m_mem_cnt;

   typedef struct {
      logic        r, i, e, m, a;
      logic [31:0] d;
      logic [5:0]  stall;
      logic        done, req, err;
      logic [31:0] rdata;
   } vec_t;

   vec_t tbl [15];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   function automatic logic [5:0] m_stall();
      if (mem_req_i && !m_done) return 6'b011111;
      if (stallreq_ex_i) return 6'b001111;
      if (stallreq_id_i) return 6'b000111;
      return 6'b000000;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_waits = 0; m_done = 0; m_req = 0; m_err = 0;
      m_rdata = 32'h0; m_stall_cnt = 0; m_mem_cnt = 0;
   endtask

   task automatic apply(input logic r, i, e, m, a, input logic [31:0] d);
      rst = r; stallreq_id_i = i; stallreq_ex_i = e;
      mem_req_i = m; bus_ack_i = a; bus_rdata_i = d;
      #1;
      check("m_stall", {26'h0, stall_o}, {26'h0, m_stall()});
      check("m_done", {31'h0, mem_done_o}, {31'h0, m_done});
      check("m_req", {31'h0, bus_req_o}, {31'h0, m_req});
      check("m_err", {31'h0, bus_err_o}, {31'h0, m_err});
      check("m_rdata", mem_rdata_o, m_rdata);
`ifdef STALL_PERF_EN
      check("m_perf", stall_cycles_o, m_stall_cnt);
      check("m_mperf", mem_stall_cycles_o, m_mem_cnt);
`endif
   endtask

   task automatic tick();
      bit mstall;
      bit anystall;
      mstall   = mem_req_i && !m_done;
      anystall = (m_stall() != 6'b000000);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (anystall) m_stall_cnt++;
         if (mstall) m_mem_cnt++;
         if (m_done) begin
            m_done = 0;
         end else if (!m_busy) begin
            if (mem_req_i) begin
               m_busy = 1; m_waits = 0; m_req = 1;
            end
         end else begin
            m_waits++;
            if (bus_ack_i) begin
               m_busy = 0; m_done = 1; m_req = 0; m_rdata = bus_rdata_i;
            end else if (m_waits == TO) begin
               m_busy = 0; m_done = 1; m_req = 0; m_rdata = 32'h0;
               m_err = 1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic cyc(input logic r, i, e, m, a, input logic [31:0] d);
      apply(r, i, e, m, a, d);
      tick();
   endtask

   initial begin
      tbl[0]  = '{0,1,0,0,0,32'h0,6'b000111,0,0,0,32'h0};
      tbl[1]  = '{0,1,1,0,0,32'h0,6'b001111,0,0,0,32'h0};
      tbl[2]  = '{0,1,1,1,0,32'h0,6'b011111,0,0,0,32'h0};
      tbl[3]  = '{0,0,0,1,0,32'h0,6'b011111,0,1,0,32'h0};
      tbl[4]  = '{0,0,0,1,0,32'h0,6'b011111,0,1,0,32'h0};
      tbl[5]  = '{0,0,0,1,1,32'hDEADBEEF,6'b011111,0,1,0,32'h0};
      tbl[6]  = '{0,0,0,1,0,32'h0,6'b000000,1,0,0,32'hDEADBEEF};
      tbl[7]  = '{0,0,0,0,0,32'h0,6'b000000,0,0,0,32'hDEADBEEF};
      tbl[8]  = '{0,0,0,1,0,32'h0,6'b011111,0,0,0,32'hDEADBEEF};
      tbl[9]  = '{0,0,0,1,0,32'h0,6'b011111,0,1,0,32'hDEADBEEF};
      tbl[10] = '{0,0,0,1,0,32'h0,6'b011111,0,1,0,32'hDEADBEEF};
      tbl[11] = '{0,0,1,1,0,32'h0,6'b011111,0,1,0,32'hDEADBEEF};
      tbl[12] = '{0,0,0,1,0,32'h0,6'b011111,0,1,0,32'hDEADBEEF};
      tbl[13] = '{0,0,1,1,0,32'h0,6'b001111,1,0,1,32'h0};
      tbl[14] = '{0,0,0,0,0,32'h0,6'b000000,0,0,1,32'h0};

      rst = 1; stallreq_id_i = 0; stallreq_ex_i = 0;
      mem_req_i = 0; bus_ack_i = 0; bus_rdata_i = 32'h0;
      model_reset();
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst = 0;
      #1;
      check("rst_stall", {26'h0, stall_o}, 32'h0);
      check("rst_req", {31'h0, bus_req_o}, 32'h0);
      check("rst_err", {31'h0, bus_err_o}, 32'h0);
      check("rst_rdata", mem_rdata_o, 32'h0);
      check("rst_done", {31'h0, mem_done_o}, 32'h0);
      @(negedge clk);

      for (int k = 0; k < 15; k++) begin
         apply(tbl[k].r, tbl[k].i, tbl[k].e, tbl[k].m, tbl[k].a, tbl[k].d);
         check($sformatf("tbl%0d_stall", k), {26'h0, stall_o},
               {26'h0, tbl[k].stall});
         check($sformatf("tbl%0d_done", k), {31'h0, mem_done_o},
               {31'h0, tbl[k].done});
         check($sformatf("tbl%0d_req", k), {31'h0, bus_req_o},
               {31'h0, tbl[k].req});
         check($sformatf("tbl%0d_err", k), {31'h0, bus_err_o},
               {31'h0, tbl[k].err});
         check($sformatf("tbl%0d_rdata", k), mem_rdata_o, tbl[k].rdata);
         tick();
      end

      // Ack on the last allowed WAIT cycle: no error.
      cyc(1, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 1, 1, 32'hCAFEF00D);
      apply(0, 0, 0, 1, 0, 32'h0);
      check("ack4_done", {31'h0, mem_done_o}, 32'h1);
      check("ack4_err", {31'h0, bus_err_o}, 32'h0);
      check("ack4_rdata", mem_rdata_o, 32'hCAFEF00D);
      tick();

      // Reset in the middle of WAIT, then a late ack.
      cyc(1, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 1, 0, 32'h0);
      apply(1, 0, 0, 1, 0, 32'h0);
      check("mid_req_before", {31'h0, bus_req_o}, 32'h1);
      tick();
      apply(0, 0, 0, 0, 1, 32'h12345678);
      check("mid_req", {31'h0, bus_req_o}, 32'h0);
      check("mid_done0", {31'h0, mem_done_o}, 32'h0);
      tick();
      for (int k = 0; k < 3; k++) begin
         apply(0, 0, 0, 0, 0, 32'h0);
         check("mid_done", {31'h0, mem_done_o}, 32'h0);
         check("mid_rdata", mem_rdata_o, 32'h0);
         check("mid_req_idle", {31'h0, bus_req_o}, 32'h0);
         tick();
      end

`ifdef STALL_PERF_EN
      cyc(1, 0, 0, 0, 0, 32'h0);
      cyc(0, 1, 0, 0, 0, 32'h0);
      cyc(0, 1, 0, 0, 0, 32'h0);
      cyc(0, 0, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 1, 1, 32'h55AA55AA);
      cyc(0, 0, 0, 1, 0, 32'h0);
      apply(0, 0, 0, 0, 0, 32'h0);
      check("perf_stall", stall_cycles_o, 32'd4);
      check("perf_mem", mem_stall_cycles_o, 32'd2);
      tick();
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic r, i, e, m, a;
         r = ($urandom_range(0, 99) == 0);
         i = ($urandom_range(0, 3) == 0);
         e = ($urandom_range(0, 3) == 0);
         m = ($urandom_range(0, 9) < 6);
         a = ($urandom_range(0, 4) == 0);
         cyc(r, i, e, m, a, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline stall controller for the five-stage core; the producer side of the `stall[5:0]` bus that every inter-stage register (if_id, id_ex, ex_mem, mem_wb) consumes. It merges stall requests from ID and EX with its own memory-bus handshake FSM for the MEM stage, and drives the stall vector that freezes upstream stages and inserts bubbles downstream. It also owns the MEM-stage bus request/acknowledge sequencing, including a timeout.

## Interface
- `TIMEOUT`, 255: WAIT cycles without `bus_ack_i` before the access is abandoned; legal range 1..2^CNT_W-1.
- `CNT_W`, 8: width of the timeout counter.

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `stallreq_id_i`  in  1  ID-stage stall request (load-use hazard)
- `stallreq_ex_i`  in  1  EX-stage stall request (multicycle mult/div)
- `mem_req_i`  in  1  instruction in MEM needs a bus access (level)
- `bus_ack_i`  in  1  bus acknowledge, one-cycle pulse
- `bus_rdata_i`  in  32  bus read data, valid with `bus_ack_i`
- `bus_req_o`  out  1  bus request, registered
- `mem_rdata_o`  out  32  captured read data, held until next capture
- `mem_done_o`  out  1  access complete this cycle (one-cycle pulse)
- `bus_err_o`  out  1  sticky timeout flag, cleared only by reset
- `stall_o`  out  6  stall vector; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = stop

## Operation
- FSM states: IDLE, WAIT, DONE (encoded 2 bits).
- IDLE: `mem_req_i`=1 -> WAIT, `bus_req_o`<=1, counter<=0. Otherwise stay.
- WAIT: `bus_req_o` held 1; counter increments each cycle.
  - `bus_ack_i`=1 -> DONE, `mem_rdata_o`<=`bus_rdata_i`, `bus_req_o`<=0.
  - else counter == TIMEOUT-1 -> DONE, `bus_err_o`<=1, `mem_rdata_o`<=32'h0, `bus_req_o`<=0.
  - ack and timeout in same cycle: ack wins, no error.
- DONE: `mem_done_o`=1 (combinational from state); -> IDLE unconditionally.
- Internal `stallreq_mem` = `mem_req_i` & (state != DONE).
- `stall_o` (combinational, priority high to low):
  - stallreq_mem: 6'b011111
  - stallreq_ex_i: 6'b001111
  - stallreq_id_i: 6'b000111
  - none: 6'b000000
- Consumer rule: stage register n inserts a bubble when stall[n]=1 and stall[n+1]=0; holds when both 1.
- `mem_req_i` dropping while in WAIT (should not happen): FSM completes the access anyway; stall follows `mem_req_i`.
- Reset values: state IDLE, counter 0, `bus_req_o` 0, `mem_rdata_o` 32'h0, `bus_err_o` 0, hence `mem_done_o` 0 and `stall_o` 6'b000000 when no requests.
- Reset mid-access (WAIT): next edge forces IDLE, `bus_req_o` 0; late `bus_ack_i` in IDLE is ignored.

## Timing
- `stall_o` has zero latency from `stallreq_id_i`, `stallreq_ex_i`, `mem_req_i` and state.
- `bus_req_o` rises the edge after `mem_req_i` seen in IDLE.
- Minimum access: IDLE (stall), WAIT with ack (stall), DONE (no stall, MEM advances) = 2 stall cycles.
- Ack in k-th WAIT cycle: k+1 stall cycles, DONE in cycle k+2.
- Timeout: TIMEOUT WAIT cycles, DONE on cycle TIMEOUT+2 relative to the IDLE detection cycle.
- Back-to-back memory instructions: DONE -> IDLE -> WAIT; one IDLE cycle between accesses.

## Configuration
- `STALL_PERF_EN` defined: adds output `stall_cycles_o` [31:0], counts cycles with `stall_o` != 0, reset to 0, wraps at 2^32; adds output `mem_stall_cycles_o` [31:0], counts cycles with stallreq_mem=1.
- Undefined: neither port nor counter exists; all other behaviour identical.

## Test plan
- Reset, no requests -> `stall_o`=6'b000000, `bus_req_o`=0, `bus_err_o`=0, `mem_rdata_o`=0.
- `stallreq_id_i`=1 alone -> 6'b000111; add `stallreq_ex_i` -> 6'b001111; add `mem_req_i` -> 6'b011111 same cycle.
- `mem_req_i`=1, ack after 3 WAIT cycles with `bus_rdata_i`=32'hDEADBEEF -> 4 stall cycles, `mem_done_o` pulse, `mem_rdata_o`=32'hDEADBEEF, stall 0 in DONE.
- TIMEOUT=4, no ack -> `bus_req_o` high 4 cycles, `bus_err_o`=1 sticky, `mem_rdata_o`=0, `mem_done_o` pulse; ack on 4th WAIT cycle instead -> `bus_err_o` stays 0.
- Assert `rst` during WAIT, then ack one cycle later -> IDLE, `bus_req_o`=0, `mem_done_o` never pulses, `mem_rdata_o`=0.
- `STALL_PERF_EN`: 2 ID-stall cycles + one 2-stall-cycle access -> `stall_cycles_o`=4, `mem_stall_cycles_o`=2.
